// File: rtl/dmem_access_ctrl_if.sv
// SRAM-side bus of the data-memory access controller.
// Controller drives the request side, SRAM answers with ack/rdata.
interface dmem_access_ctrl_if;
  logic        sram_req;
  logic        sram_wr;
  logic [3:0]  sram_wen;
  logic [31:0] sram_addr;
  logic [31:0] sram_wdata;
  logic        sram_ack;
  logic [31:0] sram_rdata;

  modport master (
    output sram_req,
    output sram_wr,
    output sram_wen,
    output sram_addr,
    output sram_wdata,
    input  sram_ack,
    input  sram_rdata
  );

  modport slave (
    input  sram_req,
    input  sram_wr,
    input  sram_wen,
    input  sram_addr,
    input  sram_wdata,
    output sram_ack,
    output sram_rdata
  );
endinterface

// File: rtl/dmem_access_ctrl.sv
// MEM-stage data access controller: align check, byte lanes,
// SRAM request/ack handshake with timeout, load extension.
module dmem_access_ctrl #(
  parameter int MAX_WAIT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  MemRead,
  input  logic [1:0]  MemWrite,
  input  logic        load_signed,
  input  logic [31:0] Aluout,
  input  logic [31:0] busB,
  output logic        stall,
  output logic [31:0] rdata,
  output logic        misalign,
  output logic        timeout_err,
  dmem_access_ctrl_if.master sram
);

  localparam int CW = $clog2(MAX_WAIT + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, next_state;

  logic          is_wr;
  logic          op;
  logic [1:0]    size;
  logic          mis;
  logic [3:0]    wen_c;
  logic [31:0]   wdata_c;
  logic          start;
  logic          req_c;
  logic          tmo;

  logic          wr_q;
  logic [3:0]    wen_q;
  logic [31:0]   addr_q;
  logic [31:0]   wdata_q;
  logic [1:0]    off_q;
  logic [1:0]    sz_q;
  logic          sgn_q;
  logic [CW-1:0] cnt_q;

  logic [7:0]    b_sel;
  logic [15:0]   h_sel;
  logic [31:0]   ld_val;

  // Decode the requested operation; a store wins over a load
  always_comb begin
    is_wr = |MemWrite;
    op    = is_wr | (|MemRead);
    size  = is_wr ? MemWrite : MemRead;
    mis   = ((size == 2'b10) & Aluout[0]) |
            ((size == 2'b11) & (|Aluout[1:0]));
    wen_c   = 4'b0000;
    wdata_c = 32'h0;
    if (is_wr) begin
      unique case (size)
        2'b01: begin
          wen_c   = 4'b0001 << Aluout[1:0];
          wdata_c = {4{busB[7:0]}};
        end
        2'b10: begin
          wen_c   = 4'b0011 << {Aluout[1], 1'b0};
          wdata_c = {2{busB[15:0]}};
        end
        default: begin
          wen_c   = 4'b1111;
          wdata_c = busB;
        end
      endcase
    end
  end

  // Pick and extend the addressed lane of the returned word
  always_comb begin
    b_sel = sram.sram_rdata[{off_q, 3'b000} +: 8];
    h_sel = off_q[1] ? sram.sram_rdata[31:16]
                     : sram.sram_rdata[15:0];
    unique case (sz_q)
      2'b01:   ld_val = {{24{sgn_q & b_sel[7]}}, b_sel};
      2'b10:   ld_val = {{16{sgn_q & h_sel[15]}}, h_sel};
      default: ld_val = sram.sram_rdata;
    endcase
  end

  assign tmo = (cnt_q == CW'(MAX_WAIT - 1));

  // Next state and combinational handshake outputs
  always_comb begin
    next_state = state;
    stall      = 1'b0;
    misalign   = 1'b0;
    req_c      = 1'b0;
    start      = 1'b0;
    unique case (state)
      IDLE: begin
        if (op) begin
          if (mis) begin
            misalign = 1'b1;
          end else begin
            stall      = 1'b1;
            start      = 1'b1;
            next_state = REQ;
          end
        end
      end
      REQ: begin
        req_c = 1'b1;
        stall = 1'b1;
        if (sram.sram_ack || tmo) begin
          next_state = DONE;
        end
      end
      DONE: begin
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
    // Reset forces every output low, even with an op present
    if (!reset) begin
      stall    = 1'b0;
      misalign = 1'b0;
      req_c    = 1'b0;
      start    = 1'b0;
    end
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Latch the access on start, count waits, capture the result
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_q        <= 1'b0;
      wen_q       <= 4'b0000;
      addr_q      <= 32'h0;
      wdata_q     <= 32'h0;
      off_q       <= 2'b00;
      sz_q        <= 2'b00;
      sgn_q       <= 1'b0;
      cnt_q       <= '0;
      rdata       <= 32'h0;
      timeout_err <= 1'b0;
    end else begin
      timeout_err <= 1'b0;
      if (start) begin
        addr_q  <= {Aluout[31:2], 2'b00};
        wr_q    <= is_wr;
        wen_q   <= wen_c;
        wdata_q <= wdata_c;
        off_q   <= Aluout[1:0];
        sz_q    <= size;
        sgn_q   <= load_signed;
        cnt_q   <= '0;
      end
      if (state == REQ) begin
        if (sram.sram_ack) begin
          if (!wr_q) begin
            rdata <= ld_val;
          end
        end else if (tmo) begin
          rdata       <= 32'h0;
          timeout_err <= 1'b1;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end
    end
  end

  assign sram.sram_req   = req_c;
  assign sram.sram_wr    = wr_q;
  assign sram.sram_wen   = wen_q;
  assign sram.sram_addr  = addr_q;
  assign sram.sram_wdata = wdata_q;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Directed bench for dmem_access_ctrl.
// Hand-computed vectors driven against an inline SRAM responder.
module tb_dmem_access_ctrl;

  logic        clk;
  logic        reset;
  logic [1:0]  MemRead;
  logic [1:0]  MemWrite;
  logic        load_signed;
  logic [31:0] Aluout;
  logic [31:0] busB;
  logic        stall;
  logic [31:0] rdata;
  logic        misalign;
  logic        timeout_err;

  dmem_access_ctrl_if bus ();

  dmem_access_ctrl #(.MAX_WAIT(15)) dut (
    .clk         (clk),
    .reset       (reset),
    .MemRead     (MemRead),
    .MemWrite    (MemWrite),
    .load_signed (load_signed),
    .Aluout      (Aluout),
    .busB        (busB),
    .stall       (stall),
    .rdata       (rdata),
    .misalign    (misalign),
    .timeout_err (timeout_err),
    .sram        (bus.master)
  );

  int n_tests = 0;
  int n_fail  = 0;

  int          stalls;
  logic        obs_wr;
  logic [3:0]  obs_wen;
  logic [31:0] obs_addr;
  logic [31:0] obs_wdata;
  logic        moved;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Start at a negedge in IDLE; return 1ns after the negedge
  // of the first non-stalled cycle (DONE, or IDLE if misaligned).
  task automatic access(input logic [1:0]  rd,
                        input logic [1:0]  wr,
                        input logic        sg,
                        input logic [31:0] a,
                        input logic [31:0] d,
                        input int          ack_at,
                        input logic [31:0] srd);
    int reqc;
    int done;
    reqc   = 0;
    done   = 0;
    stalls = 0;
    moved  = 1'b0;
    MemRead     = rd;
    MemWrite    = wr;
    load_signed = sg;
    Aluout      = a;
    busB        = d;
    for (int i = 0; i < 40; i++) begin
      #1;
      if (!stall) begin
        done = 1;
        break;
      end
      stalls++;
      if (bus.sram_req) begin
        reqc++;
        if (reqc == 1) begin
          obs_wr    = bus.sram_wr;
          obs_wen   = bus.sram_wen;
          obs_addr  = bus.sram_addr;
          obs_wdata = bus.sram_wdata;
        end else if (obs_wr    !== bus.sram_wr  ||
                     obs_wen   !== bus.sram_wen ||
                     obs_addr  !== bus.sram_addr ||
                     obs_wdata !== bus.sram_wdata) begin
          moved = 1'b1;
        end
        bus.sram_ack   = (reqc == ack_at);
        bus.sram_rdata = srd;
      end
      @(negedge clk);
      bus.sram_ack = 1'b0;
      MemRead      = 2'b00;
      MemWrite     = 2'b00;
    end
    chk("bound", done, 1);
  endtask

  initial begin
    reset          = 1'b0;
    MemRead        = 2'b11;
    MemWrite       = 2'b00;
    load_signed    = 1'b0;
    Aluout         = 32'h100;
    busB           = 32'h0;
    bus.sram_ack   = 1'b0;
    bus.sram_rdata = 32'h0;

    // Reset with an aligned op present
    repeat (2) @(negedge clk);
    #1;
    chk("rst_stall", stall, 0);
    chk("rst_req", bus.sram_req, 0);
    chk("rst_wen", bus.sram_wen, 0);
    chk("rst_addr", bus.sram_addr, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_tmo", timeout_err, 0);
    MemRead = 2'b00;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // Word load, ack on third REQ cycle
    access(2'b11, 2'b00, 1'b0, 32'h100, 32'h0, 3, 32'hDEADBEEF);
    chk("wl_stalls", stalls, 4);
    chk("wl_addr", obs_addr, 32'h100);
    chk("wl_wr", obs_wr, 0);
    chk("wl_wen", obs_wen, 0);
    chk("wl_hold", moved, 0);
    chk("wl_rdata", rdata, 32'hDEADBEEF);
    chk("wl_done_req", bus.sram_req, 0);
    chk("wl_tmo", timeout_err, 0);
    @(negedge clk);

    // Signed then unsigned byte load at offset 3, minimum latency
    access(2'b01, 2'b00, 1'b1, 32'h103, 32'h0, 1, 32'h80FFFFFF);
    chk("lbs_stalls", stalls, 2);
    chk("lbs_rdata", rdata, 32'hFFFFFF80);
    @(negedge clk);
    access(2'b01, 2'b00, 1'b0, 32'h103, 32'h0, 1, 32'h80FFFFFF);
    chk("lbu_rdata", rdata, 32'h00000080);
    @(negedge clk);

    // Half store at 0x202
    access(2'b00, 2'b10, 1'b0, 32'h202, 32'h1234ABCD, 2, 32'h0);
    chk("sh_wr", obs_wr, 1);
    chk("sh_wen", obs_wen, 4'b1100);
    chk("sh_wdata", obs_wdata, 32'hABCDABCD);
    chk("sh_addr", obs_addr, 32'h200);
    chk("sh_hold", moved, 0);
    chk("sh_rdata_kept", rdata, 32'h00000080);
    @(negedge clk);

    // Byte store at offset 1
    access(2'b00, 2'b01, 1'b0, 32'h201, 32'h00000055, 1, 32'h0);
    chk("sb_wen", obs_wen, 4'b0010);
    chk("sb_wdata", obs_wdata, 32'h55555555);
    @(negedge clk);

    // Both strobes set: treated as a word store
    access(2'b01, 2'b11, 1'b0, 32'h300, 32'hCAFEF00D, 1, 32'h11223344);
    chk("both_wr", obs_wr, 1);
    chk("both_wen", obs_wen, 4'b1111);
    chk("both_wdata", obs_wdata, 32'hCAFEF00D);
    chk("both_rdata_kept", rdata, 32'h00000080);
    @(negedge clk);

    // Half loads: signed upper half, unsigned lower half
    access(2'b10, 2'b00, 1'b1, 32'h102, 32'h0, 1, 32'h80017FFF);
    chk("lhs_rdata", rdata, 32'hFFFF8001);
    @(negedge clk);
    access(2'b10, 2'b00, 1'b0, 32'h100, 32'h0, 1, 32'h8001F00F);
    chk("lhu_rdata", rdata, 32'h0000F00F);
    @(negedge clk);

    // Misaligned word load stays in IDLE
    access(2'b11, 2'b00, 1'b0, 32'h101, 32'h0, 1, 32'h0);
    chk("mis_stalls", stalls, 0);
    chk("mis_flag", misalign, 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      chk("mis_noreq", bus.sram_req, 0);
      chk("mis_stall", stall, 0);
    end
    MemRead = 2'b00;
    #1;
    chk("mis_clear", misalign, 0);

    // Misaligned half store
    MemWrite = 2'b10;
    Aluout   = 32'h203;
    #1;
    chk("mis_sh", misalign, 1);
    MemWrite = 2'b00;
    @(negedge clk);

    // Ack while IDLE is ignored
    bus.sram_ack   = 1'b1;
    bus.sram_rdata = 32'hA5A5A5A5;
    repeat (2) @(negedge clk);
    bus.sram_ack = 1'b0;
    #1;
    chk("idle_ack_rdata", rdata, 32'h0000F00F);
    chk("idle_ack_req", bus.sram_req, 0);
    @(negedge clk);

    // Timeout: ack never comes
    access(2'b11, 2'b00, 1'b0, 32'h400, 32'h0, 0, 32'h0);
    chk("tmo_stalls", stalls, 16);
    chk("tmo_flag", timeout_err, 1);
    chk("tmo_rdata", rdata, 0);
    @(negedge clk);
    #1;
    chk("tmo_pulse", timeout_err, 0);
    @(negedge clk);

    // Reload a value so the reset check below is meaningful
    access(2'b11, 2'b00, 1'b0, 32'h104, 32'h0, 2, 32'h12345678);
    chk("wl2_rdata", rdata, 32'h12345678);
    @(negedge clk);

    // Reset asserted mid-REQ
    MemRead = 2'b11;
    Aluout  = 32'h500;
    @(negedge clk);
    MemRead = 2'b00;
    #1;
    chk("rq_req", bus.sram_req, 1);
    #1;
    reset = 1'b0;
    #1;
    chk("rq_rst_req", bus.sram_req, 0);
    chk("rq_rst_stall", stall, 0);
    chk("rq_rst_addr", bus.sram_addr, 0);
    chk("rq_rst_rdata", rdata, 0);
    @(negedge clk);
    reset = 1'b1;
    bus.sram_ack   = 1'b1;
    bus.sram_rdata = 32'h77777777;
    repeat (2) @(negedge clk);
    bus.sram_ack = 1'b0;
    #1;
    chk("late_ack_rdata", rdata, 0);
    chk("late_ack_req", bus.sram_req, 0);
    chk("late_ack_stall", stall, 0);
    @(negedge clk);

    // Normal access works after recovery
    access(2'b11, 2'b00, 1'b0, 32'h600, 32'h0, 1, 32'h0BADF00D);
    chk("post_addr", obs_addr, 32'h600);
    chk("post_rdata", rdata, 32'h0BADF00D);
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
